pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall, flush and forwarding controls of the F/D, D/E, E/M and M/W pipeline registers. It detects load-use hazards and taken branches/jumps, holds the Execute stage for multi-cycle ops (mul/div), and freezes the pipe on data-memory wait states, with a watchdog. It sits beside the datapath and observes register indices and control bits from the D, E, M and W stages.

Parameters:
MC_LAT, 4, total Execute-stage cycles of a multi-cycle op; legal range 2..16
MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before MemErr; legal range 1..65535

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
Rs1D, Rs2D  in  5  source regs in Decode
Rs1E, Rs2E  in  5  source regs in Execute
RdE, RdM, RdW  in  5  destination regs in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  write enables in E/M/W
ResultSrcE  in  2  2'b01 = load in Execute
PCSrcE  in  1  taken branch/jump resolved in Execute
McStartE  in  1  multi-cycle op present in Execute (level, valid first cycle)
MemReqM  in  1  data-memory access in Memory
MemReadyM  in  1  data memory completes access this cycle
StallF, StallD, StallE, StallM  out  1  hold PC / F-D / D-E / E-M register
FlushD, FlushE, FlushM, FlushW  out  1  load bubble into F-D / D-E / E-M / M-W register
ForwardAE, ForwardBE  out  2  ALU operand select: 00 reg, 01 W result, 10 M ALU result
McDoneE  out  1  multi-cycle result valid this cycle
MemErr  out  1  sticky memory-timeout flag

Behaviour:
- One clock: clk. Reset: rst, synchronous, active-high.
- Reset state: McState=RUN, mc_cnt=0, wait_cnt=0, MemErr=0.
- While rst=1: FlushD=FlushE=FlushM=FlushW=1, all Stall*=0, Forward*=00, McDoneE=0.
- All Stall/Flush/Forward outputs are combinational from the inputs and the current state. All counters change only on clk edges.
- memStall = MemReqM & ~MemReadyM. It has the highest priority.
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - All other flush outputs are 0.
  - wait_cnt increments each memStall cycle and saturates. It clears on any cycle with memStall=0.
  - When wait_cnt reaches MEM_TIMEOUT, MemErr sets and stays set until rst. The pipe stays stalled; the watchdog only reports.
- McState RUN, no memStall, McStartE=1:
  - StallF=StallD=StallE=1, FlushM=1.
  - Load mc_cnt=MC_LAT-2 and go to MC_BUSY.
  - PCSrcE and load-use are ignored this cycle.
- McState MC_BUSY, no memStall:
  - If mc_cnt!=0: stalls as above, FlushM=1, mc_cnt decrements.
  - If mc_cnt==0: McDoneE=1, no MC stalls, go to RUN. The op therefore occupies E for exactly MC_LAT cycles.
- MC_BUSY with memStall: state and mc_cnt hold; the memStall outputs apply.
- McState RUN, no memStall, McStartE=0:
  - lwStall = (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
  - StallF=StallD=lwStall.
  - FlushD=PCSrcE.
  - FlushE=lwStall|PCSrcE.
  - When PCSrcE and lwStall are both 1, the flush wins for D/E; StallF/D stay asserted as computed, because the taken redirect overwrites the PC.
- x0 never causes a hazard or a forward.

Optional Feature:
Macro: HAZARD_FWD_EN
- Defined (forwarding enabled):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00. ForwardBE uses the same rules with Rs2E.
  - M has priority over W.
- Undefined (forwarding disabled):
  - ForwardAE=ForwardBE=00, tied off.
  - lwStall is replaced by rawStall: any of E/M/W with RegWrite=1, Rd!=0 and Rd equal to Rs1D or Rs2D.
  - rawStall drives StallF/StallD/FlushE identically to lwStall.

Test Plan:
- Reset: assert rst for 2 cycles with McStartE=1, MemReqM=1 → FlushD/E/M/W=1, Stall*=0, MemErr=0; first cycle after release has McState=RUN.
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle; with RdE=0 → no stall. With HAZARD_FWD_EN, RdM=5, RegWriteM=1, Rs1E=5 → ForwardAE=10.
- Branch: PCSrcE=1 → FlushD=FlushE=1, StallF=0. Same cycle with McStartE=1 → MC path wins, FlushD=0.
- Multi-cycle, MC_LAT=4: McStartE=1 at cycle t → StallE=1 for t..t+2, McDoneE=1 and StallE=0 at t+3; FlushM=1 for t..t+2.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → all Stall*=1 and FlushW=1 for 3 cycles, released the cycle MemReadyM=1. With MEM_TIMEOUT=2 → MemErr sets and stays 1 until rst.
- Overlap: memStall raised at MC_BUSY with mc_cnt=1 for 2 cycles → mc_cnt held; McDoneE occurs 2 cycles later than without memStall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl                                           |
// | Purpose : Hazard and sequencing controller for a 5-stage RISC-V pipe.    |
// |           Generates stall/flush controls for the F/D, D/E, E/M and M/W   |
// |           registers, ALU operand forwarding selects, a multi-cycle       |
// |           Execute sequencer and a data-memory wait-state watchdog.       |
// | Macro   : HAZARD_FWD_EN - enables E-stage operand forwarding. Without    |
// |           it, forwarding is tied off and any pending RAW interlocks D.   |
// | Ports   : clk, rst (sync, active-high)                                   |
// |           Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW, RegWriteE/M/W, ResultSrcE,  |
// |           PCSrcE, McStartE, MemReqM, MemReadyM           (inputs)        |
// |           StallF/D/E/M, FlushD/E/M/W, ForwardAE/BE, McDoneE, MemErr      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int MC_LAT      = 4,    // Execute cycles of a multi-cycle op, 2..16
  parameter int MEM_TIMEOUT = 255   // consecutive wait cycles before MemErr
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       McStartE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       McDoneE,
  output logic       MemErr
);

  // The first Execute cycle is spent in RUN, and the last one (count==0)
  // signals done, so the counter starts at MC_LAT-2.
  localparam logic [3:0]  c_MC_LOAD   = 4'(MC_LAT - 2);
  localparam logic [15:0] c_WAIT_MAX  = 16'(MEM_TIMEOUT);
  localparam logic [15:0] c_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  mc_state_t   r_mc_state;
  mc_state_t   w_mc_state_nxt;
  logic [3:0]  r_mc_cnt;
  logic [3:0]  w_mc_cnt_nxt;
  logic [15:0] r_wait_cnt;
  logic        r_mem_err;

  logic        w_mem_stall;
  logic        w_data_stall;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_unused_inputs;

  assign w_mem_stall = MemReqM & ~MemReadyM;
  assign MemErr      = r_mem_err;

`ifdef HAZARD_FWD_EN
  // M has priority over W: it carries the younger write to that register.
  assign w_fwd_a = (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) ? 2'b10 :
                   (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ? 2'b01 : 2'b00;
  assign w_fwd_b = (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) ? 2'b10 :
                   (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ? 2'b01 : 2'b00;

  // Only a load in E cannot be forwarded in time for the consumer in D.
  assign w_data_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

  assign w_unused_inputs = RegWriteE;
`else
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;

  // No bypass network: any in-flight write to a D source must drain first.
  assign w_data_stall =
      (RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
      (RegWriteM && (RdM != 5'd0) && ((RdM == Rs1D) || (RdM == Rs2D))) ||
      (RegWriteW && (RdW != 5'd0) && ((RdW == Rs1D) || (RdW == Rs2D)));

  assign w_unused_inputs = ^{Rs1E, Rs2E, ResultSrcE};
`endif

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_state <= RUN;
      r_mc_cnt   <= 4'd0;
      r_wait_cnt <= 16'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_mc_state <= w_mc_state_nxt;
      r_mc_cnt   <= w_mc_cnt_nxt;
      if (w_mem_stall) begin
        if (r_wait_cnt != c_WAIT_MAX) begin
          r_wait_cnt <= r_wait_cnt + 16'd1;
        end
        // This cycle brings the count to the limit; the flag is sticky.
        if (r_wait_cnt >= c_WAIT_LAST) begin
          r_mem_err <= 1'b1;
        end
      end else begin
        r_wait_cnt <= 16'd0;
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    StallF         = 1'b0;
    StallD         = 1'b0;
    StallE         = 1'b0;
    StallM         = 1'b0;
    FlushD         = 1'b0;
    FlushE         = 1'b0;
    FlushM         = 1'b0;
    FlushW         = 1'b0;
    ForwardAE      = 2'b00;
    ForwardBE      = 2'b00;
    McDoneE        = 1'b0;
    w_mc_state_nxt = r_mc_state;
    w_mc_cnt_nxt   = r_mc_cnt;

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;

      if (w_mem_stall) begin
        // Freeze everything; W gets a bubble since M produces no result.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if ((r_mc_state == RUN) && McStartE) begin
        StallF         = 1'b1;
        StallD         = 1'b1;
        StallE         = 1'b1;
        FlushM         = 1'b1;
        w_mc_cnt_nxt   = c_MC_LOAD;
        w_mc_state_nxt = MC_BUSY;
      end else if ((r_mc_state == MC_BUSY) && (r_mc_cnt != 4'd0)) begin
        StallF       = 1'b1;
        StallD       = 1'b1;
        StallE       = 1'b1;
        FlushM       = 1'b1;
        w_mc_cnt_nxt = r_mc_cnt - 4'd1;
      end else begin
        if (r_mc_state == MC_BUSY) begin
          McDoneE        = 1'b1;
          w_mc_state_nxt = RUN;
        end
        // On a taken redirect F/D stay stalled but the new PC is still
        // loaded, and the bubble into D/E wins over holding it.
        StallF = w_data_stall;
        StallD = w_data_stall;
        FlushD = PCSrcE;
        FlushE = w_data_stall | PCSrcE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipeline_hazard_ctrl                                        |
// | Purpose : Self-checking bench for pipeline_hazard_ctrl: directed         |
// |           scenarios plus randomized traffic against a cycle model.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int MC_LAT      = 4;
  localparam int MEM_TIMEOUT = 2;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, McStartE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       McDoneE, MemErr;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: remaining Execute cycles of the current multi-cycle op
  // (0 = none), consecutive wait cycles, sticky error flag.
  int   m_left;
  int   m_wait;
  logic m_err;

  pipeline_hazard_ctrl #(.MC_LAT(MC_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McDoneE(McDoneE), .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW, FwdA, FwdB, McDone, MemErr}
  logic [13:0] obs;
  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                ForwardAE, ForwardBE, McDoneE, MemErr};

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; McStartE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit rd_hits(input logic [4:0] rd);
    return (rd != 5'd0) && ((rd == Rs1D) || (rd == Rs2D));
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
`else
    if (rs == 5'd31) return 2'b00;
`endif
    return 2'b00;
  endfunction

  function automatic bit model_hazard();
`ifdef HAZARD_FWD_EN
    return (ResultSrcE == 2'b01) && rd_hits(RdE);
`else
    return (RegWriteE && rd_hits(RdE)) || (RegWriteM && rd_hits(RdM)) ||
           (RegWriteW && rd_hits(RdW));
`endif
  endfunction

  function automatic logic [13:0] model_out();
    logic [3:0] st;
    logic [3:0] fl;
    logic       done;
    bit         hz;
    st = 4'b0000; fl = 4'b0000; done = 1'b0;
    if (rst) return {4'b0000, 4'b1111, 4'b0000, 1'b0, m_err};
    if (MemReqM && !MemReadyM) begin
      st = 4'b1111; fl = 4'b0001;
    end else if (m_left > 1 || (m_left == 0 && McStartE)) begin
      st = 4'b1110; fl = 4'b0010;
    end else begin
      done = (m_left == 1);
      hz   = model_hazard();
      st   = {hz, hz, 2'b00};
      fl   = {PCSrcE, hz | PCSrcE, 2'b00};
    end
    return {st, fl, model_fwd(Rs1E), model_fwd(Rs2E), done, m_err};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_left = 0; m_wait = 0; m_err = 1'b0;
    end else if (MemReqM && !MemReadyM) begin
      if (m_wait < MEM_TIMEOUT) m_wait++;
      if (m_wait >= MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      m_wait = 0;
      if (m_left > 0) m_left--;
      else if (McStartE) m_left = MC_LAT - 1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; McStartE = 1; MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 14'b0000_1111_0000_00)
        $display("FAIL reset[%0d]: got %b expected %b", i, obs, 14'b0000_1111_0000_00);
      else n_pass++;
      tick();
    end
    rst = 1'b0; MemReqM = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1110_0010_0000_00)
      $display("FAIL run_after_reset: got %b expected %b", obs, 14'b1110_0010_0000_00);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1100_0100_0000_00)
      $display("FAIL load_use_rs1: got %b expected %b", obs, 14'b1100_0100_0000_00);
    else n_pass++;
    tick();
    RdE = 0; Rs1D = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_0000_0000_00)
      $display("FAIL load_use_x0: got %b expected %b", obs, 14'b0000_0000_0000_00);
    else n_pass++;
    tick();
    RdE = 7; Rs1D = 1; Rs2D = 7;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1100_0100_0000_00)
      $display("FAIL load_use_rs2: got %b expected %b", obs, 14'b1100_0100_0000_00);
    else n_pass++;
    tick();
    idle_inputs();
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; Rs2E = 5;
`ifdef HAZARD_FWD_EN
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_0000_10_10_00)
      $display("FAIL fwd_m_priority: got %b expected %b", obs, 14'b0000_0000_10_10_00);
    else n_pass++;
    tick();
    RdM = 6;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_0000_01_01_00)
      $display("FAIL fwd_w: got %b expected %b", obs, 14'b0000_0000_01_01_00);
    else n_pass++;
`else
    Rs1D = 5;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1100_0100_0000_00)
      $display("FAIL raw_stall_m: got %b expected %b", obs, 14'b1100_0100_0000_00);
    else n_pass++;
    tick();
    RegWriteM = 0; RdW = 0; Rs1D = 0; Rs2D = 0;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_0000_0000_00)
      $display("FAIL raw_stall_x0: got %b expected %b", obs, 14'b0000_0000_0000_00);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    PCSrcE = 1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_1100_0000_00)
      $display("FAIL branch: got %b expected %b", obs, 14'b0000_1100_0000_00);
    else n_pass++;
    tick();
    ResultSrcE = 2'b01; RegWriteE = 1; RdE = 3; Rs1D = 3;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1100_1100_0000_00)
      $display("FAIL branch_lw: got %b expected %b", obs, 14'b1100_1100_0000_00);
    else n_pass++;
    tick();
    McStartE = 1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b1110_0010_0000_00)
      $display("FAIL branch_mc: got %b expected %b", obs, 14'b1110_0010_0000_00);
    else n_pass++;
    tick();
  endtask

  task automatic test_multicycle();
    logic [13:0] exp;
    do_reset();
    McStartE = 1;
    for (int i = 0; i < MC_LAT + 1; i++) begin
      // Cycle MC_LAT is a fresh op starting back-to-back.
      exp = (i == MC_LAT - 1) ? 14'b0000_0000_0000_10 : 14'b1110_0010_0000_00;
      @(negedge clk);
      n_checks++;
      if (obs !== exp)
        $display("FAIL mc_cycle[%0d]: got %b expected %b", i, obs, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_mem_wait();
    logic [13:0] exp;
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      exp = {13'b1111_0001_0000_0, (i == 2) ? 1'b1 : 1'b0};
      @(negedge clk);
      n_checks++;
      if (obs !== exp)
        $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, exp);
      else n_pass++;
      tick();
    end
    MemReadyM = 1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'b0000_0000_0000_01)
      $display("FAIL mem_release: got %b expected %b", obs, 14'b0000_0000_0000_01);
    else n_pass++;
    tick();
    MemReqM = 0;
    tick();
    @(negedge clk);
    n_checks++;
    if (MemErr !== 1'b1)
      $display("FAIL mem_err_sticky: got %b expected 1", MemErr);
    else n_pass++;
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      MemReqM = 1; MemReadyM = i[0];
      exp = i[0] ? 14'b0 : 14'b1111_0001_0000_00;
      @(negedge clk);
      n_checks++;
      if (obs !== exp)
        $display("FAIL mem_nonconsec[%0d]: got %b expected %b", i, obs, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_overlap();
    logic [13:0] exp[6];
    exp[0] = 14'b1110_0010_0000_00;
    exp[1] = 14'b1110_0010_0000_00;
    exp[2] = 14'b1111_0001_0000_00;
    exp[3] = 14'b1111_0001_0000_00;
    exp[4] = 14'b1110_0010_0000_01;
    exp[5] = 14'b0000_0000_0000_11;
    do_reset();
    McStartE = 1;
    for (int i = 0; i < 6; i++) begin
      MemReqM = (i == 2 || i == 3); MemReadyM = 0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp[i])
        $display("FAIL overlap[%0d]: got %b expected %b", i, obs, exp[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    do_reset();
    m_left = 0; m_wait = 0; m_err = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst        = (i % 60 == 59);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      McStartE   = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 2) == 0);
      MemReadyM  = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (obs !== exp)
        $display("FAIL random[%0d]: got %b expected %b", i, obs, exp);
      else n_pass++;
      model_step();
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mem_wait();
    test_overlap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
